// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet-framing controller:
// FSM state encoding, error cause codes and the default sync marker.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] ERR_CHK = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVR = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: DEPTH x 8 register array, synchronous write port and
// asynchronous read port. Storage is intentionally not reset.
module uart_pkt_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Capture payload bytes as they are written by the framing FSM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// UART packet-framing controller: hunts for SYNC_BYTE, then sequences
// length, payload and checksum; releases the buffered payload over a
// valid/ready stream only when the checksum passes. Supervises the link
// with an inter-byte timeout and reports errors with a one-cycle pulse.
// Optional macro UART_PKT_STATS_EN adds good/error packet counters.
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 52080
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Pkt_Valid,
    input  logic       i_Pkt_Ready,
    output logic [7:0] o_Pkt_Byte,
    output logic       o_Pkt_Last,
    output logic [7:0] o_Pkt_Len,
    output logic       o_Busy,
    output logic       o_Err,
    output logic [1:0] o_Err_Code
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0] o_Good_Cnt,
    output logic [15:0] o_Err_Cnt
`endif
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned PW = $clog2(MAX_LEN) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    state_e        state_q;
    logic [7:0]    len_q;
    logic [7:0]    sum_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic [TW-1:0] tmo_inc;
    logic          valid_q;
    logic [7:0]    pkt_len_q;
    logic          err_q;
    logic [1:0]    err_code_q;

    logic          counting;
    logic          tmo_fire;
    logic          len_ok;
    logic [7:0]    chk_sum;
    logic          chk_pass;
    logic          pay_last;
    logic          drain_last;
    logic          err_set;
    logic [1:0]    err_code_d;
    logic          buf_we;
    logic [7:0]    buf_rdata;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (i_Clock),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (i_Rx_Byte),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (buf_rdata)
    );

    assign buf_we = (state_q == ST_PAYLOAD) && i_Rx_DV;

    // Inter-byte timeout: a byte in the expiry cycle wins over the timeout
    always_comb begin
        tmo_inc  = tmo_q + TW'(1);
        counting = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                   (state_q == ST_CHECK);
        tmo_fire = counting && !i_Rx_DV && (tmo_inc == TMO_LAST);
        if (!counting || i_Rx_DV || tmo_fire) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_inc;
        end
    end

    // Byte classification and error cause selection for the current cycle
    always_comb begin
        len_ok     = (i_Rx_Byte != 8'd0) && (32'(i_Rx_Byte) <= MAX_LEN);
        chk_sum    = sum_q + i_Rx_Byte;
        chk_pass   = (state_q == ST_CHECK) && i_Rx_DV && (chk_sum == 8'd0);
        pay_last   = (32'(wr_ptr_q) + 32'd1) == 32'(len_q);
        drain_last = (32'(rd_ptr_q) + 32'd1) == 32'(len_q);
        err_set    = 1'b0;
        err_code_d = ERR_CHK;
        case (state_q)
            ST_LEN: begin
                if (i_Rx_DV && !len_ok) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_LEN;
                end else if (tmo_fire) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TMO;
                end
            end
            ST_PAYLOAD: begin
                if (tmo_fire) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TMO;
                end
            end
            ST_CHECK: begin
                if (i_Rx_DV && !chk_pass) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_CHK;
                end else if (tmo_fire) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TMO;
                end
            end
            ST_DRAIN: begin
                if (i_Rx_DV) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_OVR;
                end
            end
            default: ;
        endcase
    end

    // Framing FSM with registered stream and error outputs
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tmo_q      <= '0;
            valid_q    <= 1'b0;
            pkt_len_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_set;
            if (err_set) begin
                err_code_q <= err_code_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (err_set) begin
                        state_q <= ST_IDLE;
                    end else if (i_Rx_DV) begin
                        len_q    <= i_Rx_Byte;
                        sum_q    <= i_Rx_Byte;
                        wr_ptr_q <= '0;
                        state_q  <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (err_set) begin
                        state_q <= ST_IDLE;
                    end else if (i_Rx_DV) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        sum_q    <= sum_q + i_Rx_Byte;
                        if (pay_last) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (err_set) begin
                        state_q <= ST_IDLE;
                    end else if (chk_pass) begin
                        rd_ptr_q  <= '0;
                        pkt_len_q <= len_q;
                        valid_q   <= 1'b1;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (valid_q && i_Pkt_Ready) begin
                        if (drain_last) begin
                            valid_q   <= 1'b0;
                            rd_ptr_q  <= '0;
                            pkt_len_q <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Pkt_Valid = valid_q;
    assign o_Pkt_Byte  = valid_q ? buf_rdata : 8'd0;
    assign o_Pkt_Last  = valid_q && drain_last;
    assign o_Pkt_Len   = pkt_len_q;
    assign o_Busy      = (state_q != ST_IDLE);
    assign o_Err       = err_q;
    assign o_Err_Code  = err_code_q;

`ifdef UART_PKT_STATS_EN
    logic [15:0] good_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating counters of accepted packets and error pulses
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (chk_pass && (good_cnt_q != '1)) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (err_set && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign o_Good_Cnt = good_cnt_q;
    assign o_Err_Cnt  = err_cnt_q;
`endif

endmodule
